mlsu_meta_buf: RTL and testbench

Meta buffer sitting directly downstream of the MLSU control machine's meta output. It decouples request fragmentation from the data controller. Each fragmented request carries a global meta word and a segment-level meta word; the buffer stores them as pairs in a circular FIFO and presents them first-word-fall-through to the data controller. Its registered `meta_ready_o` is the inverse of the control machine's "meta buffer full" input.

---
 rtl/mlsu_pkg.sv | 12 +
 rtl/mlsu_meta_buf.sv | 84 ++++++++
 tb/tb_mlsu_meta_buf.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mlsu_pkg.sv
// mlsu_pkg: shared types and constants for the MLSU datapath.
//   meta_glb_t   - global (request-level) meta word
//   meta_seglv_t - segment-level meta word
//   MetaBufDepth - default number of entries in the meta buffer
package mlsu_pkg;

    typedef logic [7:0] meta_glb_t;
    typedef logic [7:0] meta_seglv_t;

    localparam int unsigned MetaBufDepth = 4;

endpackage

// File: rtl/mlsu_meta_buf.sv
// mlsu_meta_buf: circular FIFO of {glb, seglv} meta pairs between the MLSU
// control machine and the data controller, presented first-word-fall-through.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset (clears pointers only)
//   meta_valid_i  enqueue valid
//   meta_ready_o  enqueue ready, high when not full (from pointer registers only)
//   meta_glb_i    enqueue global meta
//   meta_seglv_i  enqueue segment meta
//   meta_valid_o  dequeue valid, high when not empty
//   meta_ready_i  dequeue ready
//   meta_glb_o    head global meta (don't-care while meta_valid_o is low)
//   meta_seglv_o  head segment meta (don't-care while meta_valid_o is low)
//   usage_o       number of occupied entries, 0..Depth
module mlsu_meta_buf #(
    parameter int unsigned Depth        = mlsu_pkg::MetaBufDepth,
    parameter type         meta_glb_t   = mlsu_pkg::meta_glb_t,
    parameter type         meta_seglv_t = mlsu_pkg::meta_seglv_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       meta_valid_i,
    output logic                       meta_ready_o,
    input  meta_glb_t                  meta_glb_i,
    input  meta_seglv_t                meta_seglv_i,
    output logic                       meta_valid_o,
    input  logic                       meta_ready_i,
    output meta_glb_t                  meta_glb_o,
    output meta_seglv_t                meta_seglv_o,
    output logic [$clog2(Depth+1)-1:0] usage_o
);

    localparam int unsigned IdxW   = $clog2(Depth);
    localparam int unsigned PtrW   = IdxW + 1;
    localparam int unsigned UsageW = $clog2(Depth+1);

    meta_glb_t   glb_mem   [Depth];
    meta_seglv_t seglv_mem [Depth];

    // MSB of each pointer is a wrap bit; equal indices with differing wrap
    // bits means the writer has lapped the reader exactly once (full).
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            empty;
    logic            full;
    logic            enq;
    logic            deq;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IdxW-1:0] == rd_ptr[IdxW-1:0]) &&
                   (wr_ptr[IdxW] != rd_ptr[IdxW]);

    assign meta_ready_o = !full;
    assign meta_valid_o = !empty;

    assign enq = meta_valid_i && meta_ready_o;
    assign deq = meta_valid_o && meta_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PtrW'(1);
            if (deq) rd_ptr <= rd_ptr + PtrW'(1);
        end
    end

    // Data path carries no reset; entries are only meaningful between pointers.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            glb_mem[wr_ptr[IdxW-1:0]]   <= meta_glb_i;
            seglv_mem[wr_ptr[IdxW-1:0]] <= meta_seglv_i;
        end
    end

    assign meta_glb_o   = glb_mem[rd_ptr[IdxW-1:0]];
    assign meta_seglv_o = seglv_mem[rd_ptr[IdxW-1:0]];

    // Modulo-2*Depth difference of the pointers is the occupancy.
    assign usage_o = UsageW'(wr_ptr - rd_ptr);

endmodule

// File: tb/tb_mlsu_meta_buf.sv
module tb_mlsu_meta_buf;

    localparam int Depth = 4;

    logic       clk;
    logic       rst_n;
    logic       meta_valid_i;
    logic       meta_ready_o;
    logic [7:0] meta_glb_i;
    logic [7:0] meta_seglv_i;
    logic       meta_valid_o;
    logic       meta_ready_i;
    logic [7:0] meta_glb_o;
    logic [7:0] meta_seglv_o;
    logic [2:0] usage_o;

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy count and in-order scoreboard of {glb, seglv}.
    logic [15:0] sb_q[$];
    int          mdl_cnt = 0;
    int          n_enq   = 0;

    mlsu_meta_buf dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .meta_valid_i (meta_valid_i),
        .meta_ready_o (meta_ready_o),
        .meta_glb_i   (meta_glb_i),
        .meta_seglv_i (meta_seglv_i),
        .meta_valid_o (meta_valid_o),
        .meta_ready_i (meta_ready_i),
        .meta_glb_o   (meta_glb_o),
        .meta_seglv_o (meta_seglv_o),
        .usage_o      (usage_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] g, input logic r);
        meta_valid_i = v;
        meta_glb_i   = g;
        meta_seglv_i = g ^ 8'h5A;
        meta_ready_i = r;
    endtask

    // One clock: check DUT state against the model at negedge, then advance
    // the model across the posedge using the model's own full/empty view.
    task automatic step(input string tag);
        logic do_enq;
        logic do_deq;
        @(negedge clk);
        chk({tag, ".usage"}, 16'(usage_o), 16'(mdl_cnt));
        chk({tag, ".valid_o"}, 16'(meta_valid_o), 16'(mdl_cnt != 0));
        chk({tag, ".ready_o"}, 16'(meta_ready_o), 16'(mdl_cnt != Depth));
        if (mdl_cnt != 0)
            chk({tag, ".head"}, {meta_glb_o, meta_seglv_o}, sb_q[0]);
        do_enq = meta_valid_i && (mdl_cnt != Depth);
        do_deq = meta_ready_i && (mdl_cnt != 0);
        @(posedge clk);
        if (do_deq) begin
            void'(sb_q.pop_front());
            mdl_cnt--;
        end
        if (do_enq) begin
            sb_q.push_back({meta_glb_i, meta_seglv_i});
            mdl_cnt++;
            n_enq++;
        end
        #1;
    endtask

    initial begin
        int cyc;
        drive(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready_o", 16'(meta_ready_o), 16'd1);
        chk("rst.valid_o", 16'(meta_valid_o), 16'd0);
        chk("rst.usage", 16'(usage_o), 16'd0);
        rst_n = 1'b1;

        // Idle with dequeue ready: nothing moves.
        drive(1'b0, 8'h00, 1'b1);
        repeat (5) step("idle");

        // Fill to full with backpressure, then a dropped 5th write.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            step("fill");
        end
        drive(1'b1, 8'h05, 1'b0);
        step("fill_drop");
        drive(1'b0, 8'h00, 1'b0);
        step("full_hold");
        chk("full.head_glb", 16'(meta_glb_o), 16'h0001);

        // Drain from full.
        drive(1'b0, 8'h00, 1'b1);
        repeat (4) step("drain");
        step("drain_empty");
        chk("drain.valid_o", 16'(meta_valid_o), 16'd0);

        // Streaming at one entry per cycle.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b1);
            step("stream");
        end
        drive(1'b0, 8'h00, 1'b1);
        step("stream_tail");
        step("stream_empty");

        // Random backpressure until 200 entries accepted.
        n_enq = 0;
        cyc   = 0;
        while (n_enq < 200 && cyc < 4000) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            step("rand");
            cyc++;
        end
        chk("rand.enq_count", 16'(n_enq), 16'd200);
        cyc = 0;
        drive(1'b0, 8'h00, 1'b1);
        while (mdl_cnt != 0 && cyc < 20) begin
            step("rand_drain");
            cyc++;
        end
        chk("rand.drained", 16'(mdl_cnt), 16'd0);

        // Asynchronous reset with 3 entries held.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b0);
            step("prerst");
        end
        drive(1'b0, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid_o", 16'(meta_valid_o), 16'd0);
        chk("arst.usage", 16'(usage_o), 16'd0);
        sb_q.delete();
        mdl_cnt = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step("postrst");
        drive(1'b1, 8'hAA, 1'b0);
        step("enq_aa");
        drive(1'b0, 8'h00, 1'b0);
        step("aa_head");
        chk("aa.head_glb", 16'(meta_glb_o), 16'h00AA);
        drive(1'b0, 8'h00, 1'b1);
        step("aa_drain");
        step("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
